// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : In-order instruction fetch with a DEPTH-entry buffer,      |
// |               redirect flush and discard of stale memory responses.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam logic [2:0] c_DEPTH = 3'(DEPTH);
    localparam logic [1:0] c_LAST  = 2'(DEPTH - 1);

    logic [31:0] r_fetch_pc;
    logic [2:0]  r_inflight;
    logic [2:0]  r_discard;
    logic [2:0]  r_buf_cnt;

    // Storage sized for the largest legal DEPTH; only DEPTH slots are used.
    logic [31:0] r_pcq       [4];
    logic [31:0] r_buf_pc    [4];
    logic [31:0] r_buf_instr [4];
    logic [1:0]  r_pcq_rp;
    logic [1:0]  r_pcq_wp;
    logic [1:0]  r_buf_rp;
    logic [1:0]  r_buf_wp;

    logic        w_grant;
    logic        w_resp_live;
    logic        w_resp_drop;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_inflight_nxt;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == c_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign imem_addr_o    = r_fetch_pc;
    assign imem_req_o     = !rst_i && ((r_inflight + r_buf_cnt) < c_DEPTH);
    assign w_grant        = imem_req_o && imem_gnt_i;
    assign w_resp_live    = imem_rvalid_i && (r_discard == 3'd0);
    assign w_resp_drop    = imem_rvalid_i && (r_discard != 3'd0);
    assign w_push         = w_resp_live && !redirect_i;
    assign w_pop          = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_inflight_nxt = r_inflight + {2'b00, w_grant} - {2'b00, imem_rvalid_i};

    assign instr_valid_o  = (r_buf_cnt != 3'd0);
    assign instr_o        = r_buf_instr[r_buf_rp];
    assign instr_pc_o     = r_buf_pc[r_buf_rp];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 3'd0;
            r_discard  <= 3'd0;
            r_buf_cnt  <= 3'd0;
            r_pcq_rp   <= 2'd0;
            r_pcq_wp   <= 2'd0;
            r_buf_rp   <= 2'd0;
            r_buf_wp   <= 2'd0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect_i) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                r_discard  <= w_inflight_nxt;
                r_buf_cnt  <= 3'd0;
                r_pcq_rp   <= 2'd0;
                r_pcq_wp   <= 2'd0;
                r_buf_rp   <= 2'd0;
                r_buf_wp   <= 2'd0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_pcq_wp   <= f_next(r_pcq_wp);
                end
                if (w_resp_drop) begin
                    r_discard <= r_discard - 3'd1;
                end
                if (w_push) begin
                    r_pcq_rp <= f_next(r_pcq_rp);
                    r_buf_wp <= f_next(r_buf_wp);
                end
                if (w_pop) begin
                    r_buf_rp <= f_next(r_buf_rp);
                end
                r_buf_cnt <= r_buf_cnt + {2'b00, w_push} - {2'b00, w_pop};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !redirect_i) begin
            if (w_grant) begin
                r_pcq[r_pcq_wp] <= r_fetch_pc;
            end
            if (w_push) begin
                r_buf_pc[r_buf_wp]    <= r_pcq[r_pcq_rp];
                r_buf_instr[r_buf_wp] <= imem_rdata_i;
            end
        end
    end

    a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (r_inflight != 3'd0));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_push && !w_pop) |-> (r_buf_cnt < c_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic g, input logic v, input logic [31:0] d,
                       input logic rdy, input logic rd, input logic [31:0] rp);
        rst           = 1'b0;
        imem_gnt_i    = g;
        imem_rvalid_i = v;
        imem_rdata_i  = d;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rp;
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, gnt, rvalid;
        logic [31:0] rdata;
        logic        ready, redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc, instr;
    } vec_t;

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D4 = 32'h0040_0093;
    localparam logic [31:0] D8 = 32'h0080_0113;
    localparam logic [31:0] DC = 32'h00C0_0193;
    localparam logic [31:0] DF = 32'hFFF0_0213;

    vec_t vecs [13];

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          gcyc;
        logic        drop;
    } inf_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic [31:0] m_pc;
    inf_t        m_inf[$];
    ent_t        m_buf[$];
    inf_t        m_e;
    logic        m_req, m_valid, m_g;

    initial begin
        vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
        vecs[1]  = '{1'b0,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
        vecs[2]  = '{1'b0,1'b1,1'b1,D0,   1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b0,32'h0,        32'h0};
        vecs[3]  = '{1'b0,1'b1,1'b1,D4,   1'b1,1'b0,32'h0,        1'b0,32'h8,        1'b1,32'h0,        D0};
        vecs[4]  = '{1'b0,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h4,        D4};
        vecs[5]  = '{1'b0,1'b1,1'b1,D8,   1'b1,1'b0,32'h0,        1'b1,32'hC,        1'b0,32'h0,        32'h0};
        vecs[6]  = '{1'b0,1'b1,1'b1,DC,   1'b1,1'b0,32'h0,        1'b0,32'h10,       1'b1,32'h8,        D8};
        vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,1'b1,1'b1,32'h203,      1'b1,32'h10,       1'b1,32'hC,        DC};
        vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,1'b1,1'b1,32'hFFFF_FFFF,1'b1,32'h200,      1'b0,32'h0,        32'h0};
        vecs[9]  = '{1'b0,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,32'h0,        32'h0};
        vecs[10] = '{1'b0,1'b0,1'b1,DF,   1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
        vecs[11] = '{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'hFFFF_FFFC,DF};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};

        @(negedge clk);
        do_reset();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            rst           = vecs[i].rst;
            imem_gnt_i    = vecs[i].gnt;
            imem_rvalid_i = vecs[i].rvalid;
            imem_rdata_i  = vecs[i].rdata;
            instr_ready_i = vecs[i].ready;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            #1;
            chk($sformatf("vec%0d req", i),   32'(imem_req_o),    32'(vecs[i].req));
            chk($sformatf("vec%0d addr", i),  imem_addr_o,        vecs[i].addr);
            chk($sformatf("vec%0d valid", i), 32'(instr_valid_o), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d pc", i),    instr_pc_o, vecs[i].pc);
                chk($sformatf("vec%0d instr", i), instr_o,    vecs[i].instr);
            end
            tick();
        end

        // Decode stalled: buffer fills, requests stop, head held stable.
        do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); chk("stall c1 req", 32'(imem_req_o), 32'd1); tick();
        drv(1'b1, 1'b1, D0,    1'b0, 1'b0, 32'h0); chk("stall c2 addr", imem_addr_o, 32'h4); tick();
        drv(1'b1, 1'b1, D4,    1'b0, 1'b0, 32'h0); chk("stall c3 req", 32'(imem_req_o), 32'd0); tick();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); chk("stall c4 req", 32'(imem_req_o), 32'd0);
        chk("stall c4 pc", instr_pc_o, 32'h0); chk("stall c4 instr", instr_o, D0); tick();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); chk("stall c5 req", 32'(imem_req_o), 32'd0);
        chk("stall c5 pc", instr_pc_o, 32'h0); chk("stall c5 instr", instr_o, D0); tick();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("stall c6 valid", 32'(instr_valid_o), 32'd1); tick();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("stall c7 req", 32'(imem_req_o), 32'd1);
        chk("stall c7 addr", imem_addr_o, 32'h8); chk("stall c7 pc", instr_pc_o, 32'h4); tick();

        // Redirect with two requests in flight: both responses dropped.
        do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("rdr c2 addr", imem_addr_o, 32'h4); tick();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100); chk("rdr c3 req", 32'(imem_req_o), 32'd0); tick();
        drv(1'b0, 1'b1, 32'hBAD0, 1'b1, 1'b0, 32'h0); chk("rdr c4 valid", 32'(instr_valid_o), 32'd0);
        chk("rdr c4 req", 32'(imem_req_o), 32'd0); tick();
        drv(1'b1, 1'b1, 32'hBAD4, 1'b1, 1'b0, 32'h0); chk("rdr c5 addr", imem_addr_o, 32'h100);
        chk("rdr c5 valid", 32'(instr_valid_o), 32'd0); tick();
        drv(1'b0, 1'b1, 32'hC100, 1'b1, 1'b0, 32'h0); chk("rdr c6 valid", 32'(instr_valid_o), 32'd0); tick();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("rdr c7 valid", 32'(instr_valid_o), 32'd1);
        chk("rdr c7 pc", instr_pc_o, 32'h100); chk("rdr c7 instr", instr_o, 32'hC100); tick();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("rdr c8 valid", 32'(instr_valid_o), 32'd0); tick();

        // Redirect in the same cycle as a push and a pop.
        do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
        drv(1'b1, 1'b1, D0,    1'b1, 1'b0, 32'h0); tick();
        drv(1'b1, 1'b1, D4,    1'b1, 1'b1, 32'h40); chk("coin c3 pc", instr_pc_o, 32'h0); tick();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("coin c4 valid", 32'(instr_valid_o), 32'd0);
        chk("coin c4 addr", imem_addr_o, 32'h40); chk("coin c4 req", 32'(imem_req_o), 32'd1); tick();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); chk("coin c5 valid", 32'(instr_valid_o), 32'd0); tick();

        // Randomized run against the reference model.
        do_reset();
        m_pc = RESET_PC;
        m_inf.delete();
        m_buf.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst           = (cyc == 2000) || (cyc == 2001);
            imem_gnt_i    = ($urandom % 4) != 0;
            instr_ready_i = ($urandom % 3) != 0;
            redirect_i    = !rst && (($urandom % 10) == 0);
            redirect_pc_i = $urandom;
            imem_rvalid_i = !rst && (m_inf.size() > 0) && (($urandom % 3) != 0);
            if (imem_rvalid_i && (m_inf[0].gcyc >= cyc)) imem_rvalid_i = 1'b0;
            imem_rdata_i  = imem_rvalid_i ? m_inf[0].data : $urandom;
            #1;
            m_req   = !rst && ((m_inf.size() + m_buf.size()) < DEPTH);
            m_valid = m_buf.size() > 0;
            chk("rnd req", 32'(imem_req_o), 32'(m_req));
            chk("rnd addr", imem_addr_o, m_pc);
            if (!rst) begin
                chk("rnd valid", 32'(instr_valid_o), 32'(m_valid));
                if (m_valid) begin
                    chk("rnd pc", instr_pc_o, m_buf[0].pc);
                    chk("rnd instr", instr_o, m_buf[0].instr);
                end
            end
            @(posedge clk);
            if (rst) begin
                m_pc = RESET_PC;
                m_inf.delete();
                m_buf.delete();
            end else begin
                m_g = m_req && imem_gnt_i;
                if (imem_rvalid_i) m_e = m_inf.pop_front();
                if (redirect_i) begin
                    m_buf.delete();
                    foreach (m_inf[k]) m_inf[k].drop = 1'b1;
                    if (m_g) m_inf.push_back('{pc: m_pc, data: $urandom, gcyc: cyc, drop: 1'b1});
                    m_pc = redirect_pc_i & ~32'h3;
                end else begin
                    if (m_valid && instr_ready_i) void'(m_buf.pop_front());
                    if (imem_rvalid_i && !m_e.drop) m_buf.push_back('{pc: m_e.pc, instr: m_e.data});
                    if (m_g) begin
                        m_inf.push_back('{pc: m_pc, data: $urandom, gcyc: cyc, drop: 1'b0});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
